sim_run_controller: RTL and testbench
=====================================

SIM_RUN_CONTROLLER -- requirements
Module: sim_run_controller

Interface
REQ-001 Parameters SHALL be: WIDTH, default 32, data/address/count width; RESET_CYCLES, default 4, CPU reset pulse length in clocks (>=1); MAX_CLOCKS, default 1000, RUN-cycle limit before timeout (>=1, < 2^WIDTH).
REQ-002 InputClk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  run request, single-cycle pulse or level.
REQ-005 hlt  in  1  CPU halt indication.
REQ-006 ControlBus  in  3  memory control: bit1 = read enable, bit2 = write enable, bit0 ignored.
REQ-007 AddressBus  in  WIDTH  memory address from CPU.
REQ-008 DataBusOut  in  WIDTH  write data from CPU.
REQ-009 cpu_rst  out  1  reset driven to CPU, active-high.
REQ-010 running  out  1  high while in RUN.
REQ-011 done  out  1  run finished (halt or timeout).
REQ-012 timeout  out  1  run ended by MAX_CLOCKS limit.
REQ-013 CyclesConsumed  out  WIDTH  RUN cycles counted.
REQ-014 MemReads  out  16  read cycles counted, saturating.
REQ-015 MemWrites  out  16  write cycles counted, saturating.
REQ-016 WriteChecksum  out  WIDTH  signature of all writes.

Function
REQ-017 FSM SHALL have states IDLE, RESET, RUN, DONE; all outputs registered.
REQ-018 IDLE: cpu_rst=1, running=0; start=1 -> RESET next cycle, clearing CyclesConsumed, MemReads, MemWrites, WriteChecksum, done, timeout.
REQ-019 RESET: cpu_rst=1 for exactly RESET_CYCLES clocks (internal down-counter), then -> RUN.
REQ-020 RUN: cpu_rst=0, running=1; CyclesConsumed increments by 1 every RUN cycle, including the terminating cycle.
REQ-021 RUN: ControlBus[1]=1 -> MemReads+1; ControlBus[2]=1 -> MemWrites+1; both set same cycle -> both increment; counters hold at 16'hFFFF, no wrap.
REQ-022 RUN write cycle: WriteChecksum <= rotate-left-by-1(WriteChecksum) XOR AddressBus XOR DataBusOut.
REQ-023 Bus activity outside RUN SHALL NOT alter counters or checksum.
REQ-024 RUN with hlt=1 -> DONE next cycle with done=1, timeout=0.
REQ-025 RUN with hlt=0 and incremented CyclesConsumed equal to MAX_CLOCKS -> DONE with done=1, timeout=1.
REQ-026 hlt=1 in the same cycle the limit is reached: halt wins, timeout=0; CyclesConsumed=MAX_CLOCKS.
REQ-027 Bus activity in the terminating RUN cycle SHALL be counted.
REQ-028 DONE: cpu_rst=1, running=0, all statistics and done/timeout frozen; start=1 -> RESET (rerun, statistics cleared as REQ-018).
REQ-029 start in RESET or RUN SHALL be ignored; hlt outside RUN ignored.
REQ-030 CyclesConsumed SHALL never exceed MAX_CLOCKS.

Reset
REQ-031 rst=1 SHALL force IDLE on next edge in any state: cpu_rst=1, running=0, done=0, timeout=0, CyclesConsumed=0, MemReads=0, MemWrites=0, WriteChecksum=0, RESET down-counter cleared.
REQ-032 rst=1 with start=1 same cycle: rst wins, stays IDLE.
REQ-033 rst mid-RUN SHALL abandon the run; no done pulse.

Verification (RESET_CYCLES=4, MAX_CLOCKS=20, WIDTH=32)
REQ-034 start pulse, hlt at 6th RUN cycle -> cpu_rst high exactly 4 cycles after start accepted, CyclesConsumed=6, done=1, timeout=0.
REQ-035 start, hlt never -> done=1, timeout=1, CyclesConsumed=20, running low from cycle 21.
REQ-036 two writes (A=0x10,D=0x5; A=0x14,D=0xA) plus one read/write-together cycle -> MemWrites=3, MemReads=1, WriteChecksum matches rotate-XOR model.
REQ-037 hlt asserted on 20th RUN cycle -> timeout=0, CyclesConsumed=20.
REQ-038 rst at 3rd RUN cycle -> all outputs zero, cpu_rst=1, IDLE; subsequent start runs cleanly.
REQ-039 start in DONE after a run -> statistics cleared, new 4-cycle reset pulse, fresh counts.

Source files
------------

// File: rtl/sim_run_controller.sv
// sim_run_controller: sequences a CPU run (reset pulse, run, halt/timeout) and
// gathers run statistics from the CPU memory bus.
//
// Ports:
//   InputClk       - clock, all state changes on the rising edge
//   rst            - synchronous active-high reset, forces IDLE
//   start          - run request (pulse or level), honoured in IDLE/DONE
//   hlt            - CPU halt indication, honoured in RUN only
//   ControlBus     - [1] read enable, [2] write enable, [0] unused
//   AddressBus     - CPU memory address
//   DataBusOut     - CPU write data
//   cpu_rst        - reset driven to the CPU (high outside RUN)
//   running        - high while in RUN
//   done           - run finished by halt or timeout
//   timeout        - run ended by the MAX_CLOCKS limit
//   CyclesConsumed - RUN cycles counted
//   MemReads       - read cycles counted, saturating
//   MemWrites      - write cycles counted, saturating
//   WriteChecksum  - rotate-left/XOR signature of all writes
module sim_run_controller #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned MAX_CLOCKS   = 1000
) (
    input  logic             InputClk,
    input  logic             rst,
    input  logic             start,
    input  logic             hlt,
    input  logic [2:0]       ControlBus,
    input  logic [WIDTH-1:0] AddressBus,
    input  logic [WIDTH-1:0] DataBusOut,
    output logic             cpu_rst,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [WIDTH-1:0] CyclesConsumed,
    output logic [15:0]      MemReads,
    output logic [15:0]      MemWrites,
    output logic [WIDTH-1:0] WriteChecksum
);

    localparam int unsigned CNT_W   = $clog2(RESET_CYCLES + 1);
    localparam int unsigned STAT_W  = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   rcnt_q, rcnt_d;
    logic [WIDTH-1:0]   cycles_q, cycles_d;
    logic [STAT_W-1:0]  reads_q, reads_d;
    logic [STAT_W-1:0]  writes_q, writes_d;
    logic [WIDTH-1:0]   csum_q, csum_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;
    logic               cpu_rst_q, cpu_rst_d;
    logic               running_q, running_d;

    // Bit 0 of the control bus carries no meaning for this block.
    logic unused_ctrl_bit;
    assign unused_ctrl_bit = ControlBus[0];

    // Next-state, statistics and registered-output computation.
    always_comb begin
        state_d   = state_q;
        rcnt_d    = rcnt_q;
        cycles_d  = cycles_q;
        reads_d   = reads_q;
        writes_d  = writes_q;
        csum_d    = csum_q;
        done_d    = done_q;
        timeout_d = timeout_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_RESET;
                    // Counter runs RESET_CYCLES-1 .. 0, giving RESET_CYCLES clocks in RESET.
                    rcnt_d    = CNT_W'(RESET_CYCLES - 1);
                    cycles_d  = '0;
                    reads_d   = '0;
                    writes_d  = '0;
                    csum_d    = '0;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            S_RESET: begin
                if (rcnt_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    rcnt_d = rcnt_q - CNT_W'(1);
                end
            end
            S_RUN: begin
                cycles_d = cycles_q + WIDTH'(1);
                if (ControlBus[1] && (reads_q != '1)) begin
                    reads_d = reads_q + STAT_W'(1);
                end
                if (ControlBus[2]) begin
                    if (writes_q != '1) begin
                        writes_d = writes_q + STAT_W'(1);
                    end
                    csum_d = {csum_q[WIDTH-2:0], csum_q[WIDTH-1]} ^ AddressBus ^ DataBusOut;
                end
                // Halt takes priority over a coincident timeout.
                if (hlt) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (cycles_d == WIDTH'(MAX_CLOCKS)) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cpu_rst_d = (state_d != S_RUN);
        running_d = (state_d == S_RUN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge InputClk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rcnt_q    <= '0;
            cycles_q  <= '0;
            reads_q   <= '0;
            writes_q  <= '0;
            csum_q    <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            cpu_rst_q <= 1'b1;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
            cycles_q  <= cycles_d;
            reads_q   <= reads_d;
            writes_q  <= writes_d;
            csum_q    <= csum_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            cpu_rst_q <= cpu_rst_d;
            running_q <= running_d;
        end
    end

    assign cpu_rst        = cpu_rst_q;
    assign running        = running_q;
    assign done           = done_q;
    assign timeout        = timeout_q;
    assign CyclesConsumed = cycles_q;
    assign MemReads       = reads_q;
    assign MemWrites      = writes_q;
    assign WriteChecksum  = csum_q;

endmodule

// File: tb/tb_sim_run_controller.sv
// tb_sim_run_controller: directed scenarios plus randomized traffic, checked
// every cycle against a behavioural model of the run controller.
module tb_sim_run_controller;

    localparam int unsigned WIDTH        = 32;
    localparam int unsigned RESET_CYCLES = 4;
    localparam int unsigned MAX_CLOCKS   = 20;

    logic             InputClk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             hlt = 1'b0;
    logic [2:0]       ControlBus = '0;
    logic [WIDTH-1:0] AddressBus = '0;
    logic [WIDTH-1:0] DataBusOut = '0;
    logic             cpu_rst;
    logic             running;
    logic             done;
    logic             timeout;
    logic [WIDTH-1:0] CyclesConsumed;
    logic [15:0]      MemReads;
    logic [15:0]      MemWrites;
    logic [WIDTH-1:0] WriteChecksum;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    sim_run_controller #(
        .WIDTH(WIDTH),
        .RESET_CYCLES(RESET_CYCLES),
        .MAX_CLOCKS(MAX_CLOCKS)
    ) dut (
        .InputClk(InputClk),
        .rst(rst),
        .start(start),
        .hlt(hlt),
        .ControlBus(ControlBus),
        .AddressBus(AddressBus),
        .DataBusOut(DataBusOut),
        .cpu_rst(cpu_rst),
        .running(running),
        .done(done),
        .timeout(timeout),
        .CyclesConsumed(CyclesConsumed),
        .MemReads(MemReads),
        .MemWrites(MemWrites),
        .WriteChecksum(WriteChecksum)
    );

    always #5 InputClk = ~InputClk;

    // Behavioural model: phase 0=idle,1=cpu held in reset,2=running,3=finished.
    int          m_phase   = 0;
    int          m_left    = 0;
    int          m_cycles  = 0;
    int          m_reads   = 0;
    int          m_writes  = 0;
    logic [31:0] m_csum    = '0;
    bit          m_done    = 1'b0;
    bit          m_timeout = 1'b0;

    always @(posedge InputClk) begin
        if (rst) begin
            m_phase = 0; m_left = 0; m_cycles = 0; m_reads = 0; m_writes = 0;
            m_csum = '0; m_done = 1'b0; m_timeout = 1'b0;
        end else if (m_phase == 0 || m_phase == 3) begin
            if (start) begin
                m_phase = 1; m_left = RESET_CYCLES; m_cycles = 0; m_reads = 0;
                m_writes = 0; m_csum = '0; m_done = 1'b0; m_timeout = 1'b0;
            end
        end else if (m_phase == 1) begin
            m_left = m_left - 1;
            if (m_left == 0) m_phase = 2;
        end else begin
            m_cycles = m_cycles + 1;
            if (ControlBus[1]) m_reads = (m_reads < 65535) ? m_reads + 1 : 65535;
            if (ControlBus[2]) begin
                m_writes = (m_writes < 65535) ? m_writes + 1 : 65535;
                m_csum = ((m_csum << 1) | (m_csum >> 31)) ^ AddressBus ^ DataBusOut;
            end
            if (hlt) begin
                m_phase = 3; m_done = 1'b1;
            end else if (m_cycles == MAX_CLOCKS) begin
                m_phase = 3; m_done = 1'b1; m_timeout = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge InputClk) begin
        if (chk_en) begin
            check("cpu_rst", 32'(cpu_rst), 32'(m_phase != 2));
            check("running", 32'(running), 32'(m_phase == 2));
            check("done", 32'(done), 32'(m_done));
            check("timeout", 32'(timeout), 32'(m_timeout));
            check("cycles", CyclesConsumed, 32'(m_cycles));
            check("reads", 32'(MemReads), 32'(m_reads));
            check("writes", 32'(MemWrites), 32'(m_writes));
            check("csum", WriteChecksum, m_csum);
            check("cycles_limit", 32'(CyclesConsumed <= MAX_CLOCKS), 32'd1);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge InputClk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        step(2);
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_running", 32'(running), 32'd0);
        check("rst_cycles", CyclesConsumed, 32'd0);

        // Halt on 6th RUN cycle; cpu reset lasts exactly 4 clocks.
        pulse_start();
        check("rp_first", 32'(cpu_rst), 32'd1);
        step(3);
        check("rp_last", 32'(cpu_rst), 32'd1);
        step(1);
        check("run_cpu_rst", 32'(cpu_rst), 32'd0);
        check("run_running", 32'(running), 32'd1);
        step(5);
        hlt = 1'b1;
        step(1);
        hlt = 1'b0;
        check("halt_cycles", CyclesConsumed, 32'd6);
        check("halt_done", 32'(done), 32'd1);
        check("halt_timeout", 32'(timeout), 32'd0);

        // No halt: timeout at MAX_CLOCKS.
        pulse_start();
        step(4);
        step(19);
        check("to_running19", 32'(running), 32'd1);
        step(1);
        check("to_running21", 32'(running), 32'd0);
        check("to_timeout", 32'(timeout), 32'd1);
        check("to_cycles", CyclesConsumed, 32'd20);
        step(3);
        check("to_frozen", CyclesConsumed, 32'd20);

        // Halt coincident with the limit: halt wins.
        pulse_start();
        step(4);
        step(19);
        hlt = 1'b1;
        step(1);
        hlt = 1'b0;
        check("hl_timeout", 32'(timeout), 32'd0);
        check("hl_cycles", CyclesConsumed, 32'd20);

        // Writes and a combined read/write cycle.
        pulse_start();
        step(4);
        ControlBus = 3'b100; AddressBus = 32'h10; DataBusOut = 32'h5;
        step(1);
        AddressBus = 32'h14; DataBusOut = 32'hA;
        step(1);
        ControlBus = 3'b110; AddressBus = 32'h20; DataBusOut = 32'h1;
        step(1);
        ControlBus = 3'b000;
        hlt = 1'b1;
        step(1);
        hlt = 1'b0;
        check("wr_writes", 32'(MemWrites), 32'd3);
        check("wr_reads", 32'(MemReads), 32'd1);
        check("wr_csum", WriteChecksum, 32'h49);

        // Rerun from DONE clears statistics.
        pulse_start();
        check("rr_writes", 32'(MemWrites), 32'd0);
        check("rr_csum", WriteChecksum, 32'd0);
        check("rr_done", 32'(done), 32'd0);
        step(4);

        // Reset at 3rd RUN cycle abandons the run.
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("ab_cpu_rst", 32'(cpu_rst), 32'd1);
        check("ab_cycles", CyclesConsumed, 32'd0);
        check("ab_done", 32'(done), 32'd0);
        pulse_start();
        step(4);
        hlt = 1'b1;
        step(1);
        hlt = 1'b0;
        check("ab_rerun", CyclesConsumed, 32'd1);

        // Reset and start together: stay idle.
        rst = 1'b1; start = 1'b1;
        step(1);
        rst = 1'b0; start = 1'b0;
        step(4);
        check("rs_running", 32'(running), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 99) == 0);
            start      = ($urandom_range(0, 15) == 0);
            hlt        = ($urandom_range(0, 9) == 0);
            ControlBus = 3'($urandom);
            AddressBus = $urandom;
            DataBusOut = $urandom;
            step(1);
        end
        rst = 1'b0; start = 1'b0; hlt = 1'b0; ControlBus = '0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
